// File: rtl/maindec_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : maindec_fsm_if
// Description : Control bundle between the multicycle main control FSM and
//               the MIPS datapath / shared memory.
//               master : the control FSM (drives enables and selects)
//               slave  : the datapath (drives opcode, zero flag, memready)
// Ports       : op[5:0], zero, memready                  (datapath -> FSM)
//               pcen, irwrite, memwrite, regwrite, iord,
//               memtoreg, regdst, alusrca, alusrcb[1:0],
//               pcsrc[1:0], aluop[1:0], illegal, state[3:0] (FSM -> datapath)
// Revision    : 1.0  initial release
// ============================================================================
interface maindec_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       memready;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, memready,
    output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output op, zero, memready,
    input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/maindec_fsm.sv
`default_nettype none
// ============================================================================
// Module      : maindec_fsm
// Description : Multicycle main control FSM for the MIPS datapath. Sequences
//               fetch / decode / execute / memory / writeback, drives every
//               datapath enable and mux select and the 2-bit aluop for the
//               downstream ALU decoder. memready stretches FETCH, MEMRD and
//               MEMWR.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous, active-high; forces all outputs to 0
//               bus    - maindec_fsm_if.master (opcode/zero/memready in,
//                        control strobes, selects, illegal, state out)
// Config      : MAINFSM_ADDI_EN - when defined, addi (001000) is executed
//               through ADDIEX/ADDIWB; otherwise it is an illegal opcode.
// Revision    : 1.0  initial release
// ============================================================================
module maindec_fsm (
  input  wire logic     clk,
  input  wire logic     reset,
  maindec_fsm_if.master bus
);

  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
`ifdef MAINFSM_ADDI_EN
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
`ifdef MAINFSM_ADDI_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`endif
    S_JEX     = 4'd11
  } state_t;

  // Moore control word held alongside the state register. 'fetch' marks the
  // FETCH state, whose irwrite/pcwrite are qualified by memready.
  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  state_t r_state;
  ctl_t   r_ctl;
  logic   w_op_legal;
  logic   w_run;
  logic   w_pcwrite;

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic mr);
    case (s)
      S_FETCH:   return mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          C_OP_LW, C_OP_SW: return S_MEMADR;
          C_OP_RTYPE:       return S_RTYPEEX;
          C_OP_BEQ:         return S_BEQEX;
          C_OP_J:           return S_JEX;
`ifdef MAINFSM_ADDI_EN
          C_OP_ADDI:        return S_ADDIEX;
`endif
          default:          return S_FETCH;
        endcase
      end
      S_MEMADR:  return (op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   return mr ? S_MEMWB : S_MEMRD;
      S_MEMWR:   return mr ? S_FETCH : S_MEMWR;
      S_RTYPEEX: return S_RTYPEWB;
`ifdef MAINFSM_ADDI_EN
      S_ADDIEX:  return S_ADDIWB;
`endif
      default:   return S_FETCH;  // writeback/branch/jump and unused codes
    endcase
  endfunction

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
`ifdef MAINFSM_ADDI_EN
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
`endif
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // State and its control word are loaded together, so r_ctl always matches
  // r_state while the outputs still come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctl   <= ctl_of(S_FETCH);
    end else begin
      r_state <= next_state(r_state, bus.op, bus.memready);
      r_ctl   <= ctl_of(next_state(r_state, bus.op, bus.memready));
    end
  end

  always_comb begin
    w_op_legal = 1'b0;
    case (bus.op)
      C_OP_LW, C_OP_SW, C_OP_RTYPE, C_OP_BEQ, C_OP_J: w_op_legal = 1'b1;
`ifdef MAINFSM_ADDI_EN
      C_OP_ADDI:                                      w_op_legal = 1'b1;
`endif
      default:                                        w_op_legal = 1'b0;
    endcase
  end

  // Reset masks every output in the same cycle so no strobe can fire while
  // reset is high, regardless of what the registers still hold.
  assign w_run     = ~reset;
  assign w_pcwrite = r_ctl.pcwrite | (r_ctl.fetch & bus.memready);

  assign bus.pcen     = w_run & (w_pcwrite | (r_ctl.branch & bus.zero));
  assign bus.irwrite  = w_run & r_ctl.fetch & bus.memready;
  assign bus.memwrite = w_run & r_ctl.memwrite;
  assign bus.regwrite = w_run & r_ctl.regwrite;
  assign bus.iord     = w_run & r_ctl.iord;
  assign bus.memtoreg = w_run & r_ctl.memtoreg;
  assign bus.regdst   = w_run & r_ctl.regdst;
  assign bus.alusrca  = w_run & r_ctl.alusrca;
  assign bus.alusrcb  = w_run ? r_ctl.alusrcb : 2'b00;
  assign bus.pcsrc    = w_run ? r_ctl.pcsrc   : 2'b00;
  assign bus.aluop    = w_run ? r_ctl.aluop   : 2'b00;
  assign bus.illegal  = w_run & (r_state == S_DECODE) & ~w_op_legal;
  assign bus.state    = w_run ? r_state : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_maindec_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_maindec_fsm
// Description : Directed self-checking bench for maindec_fsm. Each task walks
//               one instruction flow cycle by cycle and compares the whole
//               output vector against a table-driven model of the Moore
//               outputs, plus scenario-specific counts.
// Revision    : 1.0  initial release
// ============================================================================
module tb_maindec_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  maindec_fsm_if bus ();

  maindec_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,
  //  alusrcb,pcsrc,aluop,illegal,state}
  function automatic logic [18:0] pack();
    return {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord,
            bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.aluop, bus.illegal, bus.state};
  endfunction

  // Expected outputs for a (non-reset) cycle in state st.
  function automatic logic [18:0] exp_out(input logic [3:0] st, input logic mr,
                                          input logic z, input logic [5:0] opc);
    logic       pc, irw, mw, rw, io, m2r, rd, asa, ill, legal;
    logic [1:0] asb, ps, aop;
    {pc, irw, mw, rw, io, m2r, rd, asa, ill} = '0;
    asb = 2'b00; ps = 2'b00; aop = 2'b00;
    legal = (opc == 6'b100011) || (opc == 6'b101011) || (opc == 6'b000000) ||
            (opc == 6'b000100) || (opc == 6'b000010);
`ifdef MAINFSM_ADDI_EN
    legal = legal || (opc == 6'b001000);
`endif
    case (st)
      4'd0:  begin asb = 2'b01; irw = mr; pc = mr; end
      4'd1:  begin asb = 2'b11; ill = ~legal; end
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pc = z; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pc = 1'b1; end
      default: ;
    endcase
    return {pc, irw, mw, rw, io, m2r, rd, asa, asb, ps, aop, ill, st};
  endfunction

  task automatic test_reset();
    reset = 1'b1; bus.memready = 1'b1; bus.zero = 1'b1; bus.op = 6'b000100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (pack() !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", pack(), 19'd0);
    end
    reset = 1'b0; #1;
    checks++;
    if (pack() !== exp_out(4'd0, 1'b1, 1'b1, bus.op)) begin
      errors++; $display("FAIL reset_release_fetch: got %h expected %h",
                         pack(), exp_out(4'd0, 1'b1, 1'b1, bus.op));
    end
  endtask

  task automatic test_lw(input logic stall);
    logic [3:0] st [7];
    logic       mr [7];
    int         n;
    int         rw_cnt;
    if (stall) begin
      st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      n = 6;
    end else begin
      st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      n = 5;
    end
    rw_cnt = 0;
    bus.op = 6'b100011; bus.zero = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.memready = mr[i]; #1;
      checks++;
      if (pack() !== exp_out(st[i], mr[i], 1'b0, bus.op)) begin
        errors++; $display("FAIL lw(stall=%0d) cyc%0d: got %h expected %h",
                           stall, i, pack(), exp_out(st[i], mr[i], 1'b0, bus.op));
      end
      if (bus.regwrite === 1'b1) rw_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (rw_cnt !== 1) begin
      errors++; $display("FAIL lw_regwrite_count: got %0d expected 1", rw_cnt);
    end
  endtask

  task automatic test_sw();
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
    logic       mr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         mw_cnt = 0;
    int         rw_cnt = 0;
    bus.op = 6'b101011; bus.zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.memready = mr[i]; #1;
      checks++;
      if (pack() !== exp_out(st[i], mr[i], 1'b0, bus.op)) begin
        errors++; $display("FAIL sw cyc%0d: got %h expected %h",
                           i, pack(), exp_out(st[i], mr[i], 1'b0, bus.op));
      end
      if (bus.memwrite === 1'b1) mw_cnt++;
      if (bus.regwrite === 1'b1) rw_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (mw_cnt !== 3 || rw_cnt !== 0) begin
      errors++; $display("FAIL sw_strobes: memwrite %0d regwrite %0d expected 3 and 0",
                         mw_cnt, rw_cnt);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.op = 6'b000000; bus.zero = 1'b0; bus.memready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (pack() !== exp_out(st[i], 1'b1, 1'b0, bus.op)) begin
        errors++; $display("FAIL rtype cyc%0d: got %h expected %h",
                           i, pack(), exp_out(st[i], 1'b1, 1'b0, bus.op));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] st [3] = '{4'd0, 4'd1, 4'd8};
    bus.op = 6'b000100; bus.memready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.zero = (i == 2) ? z : ~z; #1;
      checks++;
      if (pack() !== exp_out(st[i], 1'b1, bus.zero, bus.op)) begin
        errors++; $display("FAIL beq(zero=%0d) cyc%0d: got %h expected %h",
                           z, i, pack(), exp_out(st[i], 1'b1, bus.zero, bus.op));
      end
      if (i == 2) begin
        checks++;
        if (bus.pcen !== z) begin
          errors++; $display("FAIL beq_pcen: got %b expected %b", bus.pcen, z);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_stall_jump();
    logic [3:0] st [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd11};
    logic       mr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         ir_cnt = 0;
    bus.op = 6'b000010; bus.zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.memready = mr[i]; #1;
      checks++;
      if (pack() !== exp_out(st[i], mr[i], 1'b0, bus.op)) begin
        errors++; $display("FAIL stall_j cyc%0d: got %h expected %h",
                           i, pack(), exp_out(st[i], mr[i], 1'b0, bus.op));
      end
      if (bus.irwrite === 1'b1) ir_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (ir_cnt !== 1) begin
      errors++; $display("FAIL fetch_irwrite_count: got %0d expected 1", ir_cnt);
    end
  endtask

  task automatic test_illegal(input logic [5:0] opc);
    logic [3:0] st [2] = '{4'd0, 4'd1};
    int         ill_cnt = 0;
    int         wr_cnt = 0;
    bus.op = opc; bus.zero = 1'b1; bus.memready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (pack() !== exp_out(st[i], 1'b1, 1'b1, opc)) begin
        errors++; $display("FAIL illegal(op=%b) cyc%0d: got %h expected %h",
                           opc, i, pack(), exp_out(st[i], 1'b1, 1'b1, opc));
      end
      if (bus.illegal === 1'b1) ill_cnt++;
      if (i == 1 && (bus.memwrite | bus.regwrite | bus.pcen | bus.irwrite) !== 1'b0)
        wr_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (ill_cnt !== 1 || wr_cnt !== 0) begin
      errors++; $display("FAIL illegal_pulse(op=%b): illegal %0d strobes %0d expected 1 and 0",
                         opc, ill_cnt, wr_cnt);
    end
  endtask

`ifdef MAINFSM_ADDI_EN
  task automatic test_addi();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
    bus.op = 6'b001000; bus.zero = 1'b0; bus.memready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (pack() !== exp_out(st[i], 1'b1, 1'b0, bus.op)) begin
        errors++; $display("FAIL addi cyc%0d: got %h expected %h",
                           i, pack(), exp_out(st[i], 1'b1, 1'b0, bus.op));
      end
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_addi();
    test_illegal(6'b001000);
  endtask
`endif

  task automatic test_reset_mid();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    bus.op = 6'b100011; bus.zero = 1'b1; bus.memready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (pack() !== exp_out(st[i], 1'b1, 1'b1, bus.op)) begin
        errors++; $display("FAIL reset_mid cyc%0d: got %h expected %h",
                           i, pack(), exp_out(st[i], 1'b1, 1'b1, bus.op));
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1; #1;
    checks++;
    if (pack() !== 19'd0) begin
      errors++; $display("FAIL reset_mid_forced: got %h expected %h", pack(), 19'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++;
    if (pack() !== exp_out(4'd0, 1'b1, 1'b1, bus.op)) begin
      errors++; $display("FAIL reset_mid_fetch: got %h expected %h",
                         pack(), exp_out(4'd0, 1'b1, 1'b1, bus.op));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.op = 6'b000000; bus.zero = 1'b0; bus.memready = 1'b0;
    test_reset();
    test_lw(1'b0);
    test_lw(1'b1);
    test_sw();
    test_rtype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_fetch_stall_jump();
    test_illegal(6'b111111);
    test_addi();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
